// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and lock-FSM encodings for the VGA sync blocks.
package vga_timing_pkg;

    localparam int unsigned VGA_H_SYNC_COLS    = 96;
    localparam int unsigned VGA_H_BACK_PORCH   = 48;
    localparam int unsigned VGA_TOTAL_COLS     = 800;
    localparam int unsigned VGA_ACTIVE_COLS    = 640;
    localparam int unsigned VGA_H_ACTIVE_START = VGA_H_SYNC_COLS + VGA_H_BACK_PORCH;

    localparam int unsigned VGA_V_SYNC_ROWS    = 2;
    localparam int unsigned VGA_V_BACK_PORCH   = 33;
    localparam int unsigned VGA_TOTAL_ROWS     = 525;
    localparam int unsigned VGA_ACTIVE_ROWS    = 480;
    localparam int unsigned VGA_V_ACTIVE_START = VGA_V_SYNC_ROWS + VGA_V_BACK_PORCH;

    localparam int unsigned COL_W = 11;
    localparam int unsigned ROW_W = 10;
    localparam int unsigned OUT_W = 10;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    // True when v lies in [first, first+len-1].
    function automatic logic in_window(input logic [COL_W-1:0] v,
                                       input int unsigned first,
                                       input int unsigned len);
        return (32'(v) >= first) && (32'(v) < first + len);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with falling-edge detect; flops idle high so reset never makes an edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fall_c = prev & ~sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers column/row position and lock status from free-running VGA HS/VS inputs.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL_COLS     = VGA_TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS     = VGA_TOTAL_ROWS,
    parameter int unsigned H_ACTIVE_START = VGA_H_ACTIVE_START,
    parameter int unsigned ACTIVE_COLS    = VGA_ACTIVE_COLS,
    parameter int unsigned V_ACTIVE_START = VGA_V_ACTIVE_START,
    parameter int unsigned ACTIVE_ROWS    = VGA_ACTIVE_ROWS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_H_Sync,
    input  logic             i_V_Sync,
    output logic [OUT_W-1:0] o_CountCol,
    output logic [OUT_W-1:0] o_CountRow,
    output logic             o_DE,
    output logic             o_FrameStart,
    output logic             o_Locked,
    output logic             o_ErrLine,
    output logic             o_ErrFrame,
    output logic             o_Timeout
);

    localparam logic [COL_W-1:0] COL_SAT    = COL_W'(2 * TOTAL_COLS);
    localparam logic [COL_W-1:0] LINE_LAST  = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_SAT    = '1;
    localparam logic [ROW_W-1:0] FRAME_LAST = ROW_W'(TOTAL_ROWS - 1);

    logic hs_fall_c;
    logic vs_fall_c;

    sync_edge_detect u_hs_edge (.clk(CLK), .rst(RST), .din(i_H_Sync), .fall_c(hs_fall_c));
    sync_edge_detect u_vs_edge (.clk(CLK), .rst(RST), .din(i_V_Sync), .fall_c(vs_fall_c));

    lock_state_e      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             pend_q, pend_d;
    logic             frame_c;
    logic             line_err_c;
    logic             frame_err_c;
    logic             timeout_c;
    logic             checking_c;
    logic             lock_d;

    // Next-state for counters, pending flag and lock FSM.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pend_d      = pend_q;
        state_d     = state_q;
        frame_c     = hs_fall_c & (pend_q | vs_fall_c);
        line_err_c  = hs_fall_c && (col_q != LINE_LAST);
        frame_err_c = frame_c && (row_q != FRAME_LAST);
        checking_c  = (state_q != ST_UNLOCKED);

        if (hs_fall_c) begin
            col_d = '0;
        end else if (col_q != COL_SAT) begin
            col_d = col_q + COL_W'(1);
        end
        timeout_c = (col_d == COL_SAT) && (col_q != COL_SAT);

        if (frame_c) begin
            pend_d = 1'b0;
            row_d  = '0;
        end else begin
            if (vs_fall_c) begin
                pend_d = 1'b1;
            end
            if (hs_fall_c && (row_q != ROW_SAT)) begin
                row_d = row_q + ROW_W'(1);
            end
        end

        case (state_q)
            ST_UNLOCKED: begin
                if (frame_c) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (line_err_c) begin
                    state_d = ST_UNLOCKED;
                end else if (frame_c) begin
                    state_d = frame_err_c ? ST_ACQUIRE : ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (line_err_c || frame_err_c) state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
        endcase

        // A stalled line drops lock from any state.
        if (timeout_c) begin
            state_d = ST_UNLOCKED;
        end

        lock_d = (state_d == ST_LOCKED);
    end

    // Outputs are registered from next-state so they align with the counter update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_UNLOCKED;
            col_q        <= '0;
            row_q        <= '0;
            pend_q       <= 1'b0;
            o_CountCol   <= '0;
            o_CountRow   <= '0;
            o_DE         <= 1'b0;
            o_FrameStart <= 1'b0;
            o_Locked     <= 1'b0;
            o_ErrLine    <= 1'b0;
            o_ErrFrame   <= 1'b0;
            o_Timeout    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pend_q       <= pend_d;
            o_CountCol   <= lock_d ? col_d[OUT_W-1:0] : '0;
            o_CountRow   <= lock_d ? row_d : '0;
            o_DE         <= lock_d
                            && in_window(col_d, H_ACTIVE_START, ACTIVE_COLS)
                            && in_window(COL_W'(row_d), V_ACTIVE_START, ACTIVE_ROWS);
            o_FrameStart <= lock_d && frame_c;
            o_Locked     <= lock_d;
            o_ErrLine    <= checking_c && line_err_c;
            o_ErrFrame   <= checking_c && frame_err_c;
            o_Timeout    <= checking_c && timeout_c;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shortened frame (full-width lines, 12 rows).
module tb_vga_sync_decoder;

    localparam int TC       = 800;
    localparam int TR       = 12;
    localparam int HAS      = 144;
    localparam int AC       = 640;
    localparam int VAS      = 3;
    localparam int AR       = 6;
    localparam int HS_W     = 96;
    localparam int VS_LINES = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_H_Sync = 1'b1;
    logic       i_V_Sync = 1'b1;
    logic [9:0] o_CountCol;
    logic [9:0] o_CountRow;
    logic       o_DE, o_FrameStart, o_Locked, o_ErrLine, o_ErrFrame, o_Timeout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_errline, n_errframe, n_timeout, n_fs;
    int   errline_cyc, errframe_cyc, to_cyc, fs_cyc, fs_gap, lock_rise_cyc;
    logic lock_prev = 1'b0;
    int   win_frame = -1;

    typedef struct {
        int   row;
        int   col;
        logic de;
    } win_t;
    win_t win[8];

    vga_sync_decoder #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .H_ACTIVE_START(HAS),
        .ACTIVE_COLS(AC), .V_ACTIVE_START(VAS), .ACTIVE_ROWS(AR)
    ) dut (
        .CLK(CLK), .RST(RST), .i_H_Sync(i_H_Sync), .i_V_Sync(i_V_Sync),
        .o_CountCol(o_CountCol), .o_CountRow(o_CountRow), .o_DE(o_DE),
        .o_FrameStart(o_FrameStart), .o_Locked(o_Locked), .o_ErrLine(o_ErrLine),
        .o_ErrFrame(o_ErrFrame), .o_Timeout(o_Timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_errline = 0; n_errframe = 0; n_timeout = 0; n_fs = 0;
        errline_cyc = -1; errframe_cyc = -1; to_cyc = -1;
        fs_cyc = -1; fs_gap = -1; lock_rise_cyc = -1;
    endtask

    // One clock: drive inputs, sample after the edge, log pulses and window points.
    task automatic tick(input logic hs, input logic vs);
        i_H_Sync = hs;
        i_V_Sync = vs;
        @(posedge CLK);
        #1;
        if (o_ErrLine)  begin n_errline++;  errline_cyc = cyc;  end
        if (o_ErrFrame) begin n_errframe++; errframe_cyc = cyc; end
        if (o_Timeout)  begin n_timeout++;  to_cyc = cyc;       end
        if (o_FrameStart) begin
            if (fs_cyc >= 0) fs_gap = cyc - fs_cyc;
            fs_cyc = cyc;
            n_fs++;
        end
        if (o_Locked && !lock_prev) lock_rise_cyc = cyc;
        lock_prev = o_Locked;
        if (win_frame >= 0) begin
            foreach (win[i]) begin
                if (cyc == win_frame + win[i].row * TC + 2 + win[i].col) begin
                    check($sformatf("de r%0d c%0d", win[i].row, win[i].col), o_DE, win[i].de);
                    check($sformatf("col r%0d c%0d", win[i].row, win[i].col), o_CountCol, win[i].col);
                    check($sformatf("row r%0d c%0d", win[i].row, win[i].col), o_CountRow, win[i].row);
                end
            end
        end
        cyc++;
    endtask

    task automatic send_line(input int len, input logic vlow);
        for (int c = 0; c < len; c++) tick(c >= HS_W, !vlow);
    endtask

    task automatic send_frame(input int rows, input int short_row, output int start);
        start = cyc;
        for (int r = 0; r < rows; r++) send_line((r == short_row) ? TC - 1 : TC, r < VS_LINES);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " col"}, o_CountCol, 0);
        check({tag, " row"}, o_CountRow, 0);
        check({tag, " de"}, o_DE, 0);
        check({tag, " fs"}, o_FrameStart, 0);
        check({tag, " locked"}, o_Locked, 0);
        check({tag, " errline"}, o_ErrLine, 0);
        check({tag, " errframe"}, o_ErrFrame, 0);
        check({tag, " timeout"}, o_Timeout, 0);
    endtask

    initial begin
        int f;
        int llast;
        win[0] = '{row: VAS,      col: HAS,          de: 1'b1};
        win[1] = '{row: VAS,      col: HAS - 1,      de: 1'b0};
        win[2] = '{row: VAS,      col: HAS + AC - 1, de: 1'b1};
        win[3] = '{row: VAS,      col: HAS + AC,     de: 1'b0};
        win[4] = '{row: VAS + AR, col: 400,          de: 1'b0};
        win[5] = '{row: VAS + AR - 1, col: 400,      de: 1'b1};
        win[6] = '{row: VAS - 1,  col: HAS,          de: 1'b0};
        win[7] = '{row: 0,        col: 0,            de: 1'b0};
        clear_stats();

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        check_all_zero("reset");
        RST = 1'b0;

        // Clean lock: acquire on first frame start, lock on the second
        clear_stats();
        send_frame(TR, -1, f);
        check("locked after frame1", o_Locked, 0);
        send_frame(TR, -1, f);
        check("lock rise cycle", lock_rise_cyc, f + 2);
        check("first fs cycle", fs_cyc, f + 2);
        win_frame = cyc;
        send_frame(TR, -1, f);
        win_frame = -1;
        check("fs gap", fs_gap, TC * TR);
        check("fs count", n_fs, 2);
        check("clean errline", n_errline, 0);
        check("clean errframe", n_errframe, 0);
        check("clean timeout", n_timeout, 0);

        // Line error: one short line, then relock two frame starts later
        clear_stats();
        send_frame(TR, 5, f);
        check("errline cycle", errline_cyc, f + 5 * TC + (TC - 1) + 2);
        check("locked after short line", o_Locked, 0);
        send_frame(TR, -1, f);
        check("still unlocked in acquire", o_Locked, 0);
        send_frame(TR, -1, f);
        check("line relock cycle", lock_rise_cyc, f + 2);
        check("errline count", n_errline, 1);
        check("errframe after line err", n_errframe, 0);

        // Frame error: short frame while locked
        clear_stats();
        send_frame(TR - 1, -1, f);
        send_frame(TR, -1, f);
        check("errframe cycle", errframe_cyc, f + 2);
        check("errframe count", n_errframe, 1);
        check("errline during frame err", n_errline, 0);
        check("locked after short frame", o_Locked, 0);
        send_frame(TR, -1, f);
        send_frame(TR, -1, f);
        check("locked before timeout", o_Locked, 1);

        // Timeout: HS stops after three lines
        clear_stats();
        llast = cyc + 2 * TC;
        for (int r = 0; r < 3; r++) send_line(TC, r < VS_LINES);
        for (int i = 0; i < 2000; i++) tick(1'b1, 1'b1);
        check("timeout count", n_timeout, 1);
        check("timeout cycle", to_cyc, llast + 2 + 2 * TC);
        check("locked after timeout", o_Locked, 0);
        check("errline during timeout", n_errline, 0);

        // Mid-frame reset, then full re-acquisition
        clear_stats();
        send_frame(TR, -1, f);
        send_frame(TR, -1, f);
        for (int r = 0; r < 6; r++) send_line(TC, r < VS_LINES);
        for (int c = 0; c < TC; c++) begin
            if (c == 40) begin
                check("locked before reset", o_Locked, 1);
                RST = 1'b1;
            end
            tick(c >= HS_W, 1'b1);
            if (c == 40) begin
                RST = 1'b0;
                check_all_zero("midreset");
            end
        end
        for (int r = 7; r < TR; r++) send_line(TC, 1'b0);
        lock_rise_cyc = -1;
        send_frame(TR, -1, f);
        check("unlocked after reset frame1", o_Locked, 0);
        send_frame(TR, -1, f);
        check("reset relock cycle", lock_rise_cyc, f + 2);
        check("reset errline", n_errline, 0);
        check("reset errframe", n_errframe, 0);
        check("reset timeout", n_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
